// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral page: register offsets, load/store
// size encoding, and lane helpers used by both this block and the data memory.
package mmio_pkg;

  localparam logic [7:0] OFF_LED    = 8'hF0;
  localparam logic [7:0] OFF_RGB    = 8'hF4;
  localparam logic [7:0] OFF_MILLIS = 8'hF8;
  localparam logic [7:0] OFF_MICROS = 8'hFC;
  localparam logic [7:0] PCNT_TOP   = 8'hFF;

  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_BU = 3'b100,
    MS_HU = 3'b101
  } mem_size_e;

  // Right-align the addressed lane(s) and extend; misaligned or unknown sizes give 0.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  funct3);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lane, 3'b000};
    res = 32'h0;
    case (mem_size_e'(funct3))
      MS_B:  res = {{24{sh[7]}}, sh[7:0]};
      MS_BU: res = {24'h0, sh[7:0]};
      MS_H:  if (!lane[0]) res = {{16{sh[15]}}, sh[15:0]}; else res = 32'h0;
      MS_HU: if (!lane[0]) res = {16'h0, sh[15:0]}; else res = 32'h0;
      MS_W:  if (lane == 2'b00) res = word; else res = 32'h0;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] lane, input logic [2:0] funct3);
    logic [3:0] m;
    m = 4'b0000;
    case (mem_size_e'(funct3))
      MS_B:  m = 4'b0001 << lane;
      MS_H:  if (lane[0]) m = 4'b0000; else m = 4'b0011 << lane;
      MS_W:  if (lane != 2'b00) m = 4'b0000; else m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_peripherals_pwm_channel.sv
// One PWM channel: duty is latched into a shadow at the end of each period so a
// period never changes length half-way through.
module pwm_channel
  import mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty_i,
  input  logic [7:0] pcnt_i,
  output logic       pwm_o
);

  logic [7:0] shadow_q, shadow_d;
  logic [7:0] pcnt_nxt_s;
  logic       pwm_q, pwm_d;

  // Next shadow and the output for the upcoming counter value, so pwm_q equals pcnt < shadow.
  always_comb begin
    pcnt_nxt_s = pcnt_i + 8'd1;
    if (pcnt_i == PCNT_TOP) begin
      shadow_d = duty_i;
    end else begin
      shadow_d = shadow_q;
    end
    pwm_d = (pcnt_nxt_s < shadow_d);
  end

  // Shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 8'h00;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/mmio_peripherals.sv
// MMIO responder: LED/RGB PWM duty registers plus microsecond/millisecond timers.
// Timers are built only when MMIO_TIMER_EN is defined; otherwise they read as 0.
module mmio_peripherals
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam logic [31:0] LED_MASK = 32'h0000_00FF;
  localparam logic [31:0] RGB_MASK = 32'h00FF_FFFF;

  if ((CLK_HZ % 1_000_000) != 0 || CLK_HZ < 1_000_000) begin : g_clk_check
    $error("CLK_HZ must be a nonzero multiple of 1 MHz");
  end

  logic [31:0] led_duty_q, led_duty_d;
  logic [31:0] rgb_duty_q, rgb_duty_d;
  logic [31:0] read_data_q, read_data_d;
  logic        hit_q, hit_d;
  logic [7:0]  pcnt_q;
  logic [31:0] millis_s, micros_s;
  logic        wr_page_s, rd_win_s;
  logic [3:0]  wr_be_s;
  logic [31:0] wr_data_s, rd_word_s;

  assign wr_page_s = (write_address[31:8] == BASE_ADDR[31:8]);
  assign wr_be_s   = store_mask(write_address[1:0], funct3);
  assign wr_data_s = write_data << {write_address[1:0], 3'b000};
  assign rd_win_s  = (read_address[31:8] == BASE_ADDR[31:8]) && (read_address[7:4] == 4'hF);

  // Store decode into the writable duty registers; reserved bits stay zero.
  always_comb begin
    led_duty_d = led_duty_q;
    rgb_duty_d = rgb_duty_q;
    if (write_mem && wr_page_s) begin
      case ({write_address[7:2], 2'b00})
        OFF_LED: led_duty_d = byte_merge(led_duty_q, wr_data_s, wr_be_s) & LED_MASK;
        OFF_RGB: rgb_duty_d = byte_merge(rgb_duty_q, wr_data_s, wr_be_s) & RGB_MASK;
        default: begin
          led_duty_d = led_duty_q;
          rgb_duty_d = rgb_duty_q;
        end
      endcase
    end else begin
      led_duty_d = led_duty_q;
      rgb_duty_d = rgb_duty_q;
    end
  end

  // Load path: pre-write register values, so a same-edge store is not visible.
  always_comb begin
    case ({read_address[7:2], 2'b00})
      OFF_LED:    rd_word_s = led_duty_q;
      OFF_RGB:    rd_word_s = rgb_duty_q;
      OFF_MILLIS: rd_word_s = millis_s;
      OFF_MICROS: rd_word_s = micros_s;
      default:    rd_word_s = 32'h0;
    endcase
    if (rd_win_s) begin
      read_data_d = lane_extract(rd_word_s, read_address[1:0], funct3);
    end else begin
      read_data_d = 32'h0;
    end
    hit_d = rd_win_s;
  end

  // Register state and the shared PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_duty_q  <= 32'h0;
      rgb_duty_q  <= 32'h0;
      read_data_q <= 32'h0;
      hit_q       <= 1'b0;
      pcnt_q      <= 8'h00;
    end else begin
      led_duty_q  <= led_duty_d;
      rgb_duty_q  <= rgb_duty_d;
      read_data_q <= read_data_d;
      hit_q       <= hit_d;
      pcnt_q      <= pcnt_q + 8'd1;
    end
  end

`ifdef MMIO_TIMER_EN
  localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ / 1_000_000 - 1);

  logic [31:0] presc_q;
  logic [9:0]  sub_q;
  logic [31:0] micros_q, millis_q;

  // Prescaler, microsecond counter and millisecond sub-divider, all carrying on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= 32'h0;
      sub_q    <= 10'd0;
      micros_q <= 32'h0;
      millis_q <= 32'h0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q  <= 32'h0;
      micros_q <= micros_q + 32'd1;
      if (sub_q == 10'd999) begin
        sub_q    <= 10'd0;
        millis_q <= millis_q + 32'd1;
      end else begin
        sub_q <= sub_q + 10'd1;
      end
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  assign micros_s = micros_q;
  assign millis_s = millis_q;
`else
  assign micros_s = 32'h0;
  assign millis_s = 32'h0;
`endif

  pwm_channel u_led   (.clk(clk), .rst_n(rst_n), .duty_i(led_duty_q[7:0]),   .pcnt_i(pcnt_q), .pwm_o(led));
  pwm_channel u_red   (.clk(clk), .rst_n(rst_n), .duty_i(rgb_duty_q[7:0]),   .pcnt_i(pcnt_q), .pwm_o(red));
  pwm_channel u_green (.clk(clk), .rst_n(rst_n), .duty_i(rgb_duty_q[15:8]),  .pcnt_i(pcnt_q), .pwm_o(green));
  pwm_channel u_blue  (.clk(clk), .rst_n(rst_n), .duty_i(rgb_duty_q[23:16]), .pcnt_i(pcnt_q), .pwm_o(blue));

  assign read_data = read_data_q;
  assign hit       = hit_q;

endmodule
